csr_access_unit: RTL and testbench
==================================

Name: csr_access_unit

Overview:
- Initiator side of the machine-mode CSR register file port.
- Takes one decoded Zicsr instruction (CSRRW/CSRRS/CSRRC and the immediate forms) from the execute stage.
- Sequences the read strobe, captures the old value, computes and issues the write strobe, then returns the old value for rd writeback.
- Never drives read and write strobes in the same cycle, because the CSR file gives write priority.

Parameters:
- ADDR_W, 32, width of csr_address (matches the CSR file address port); the upper ADDR_W-12 bits are always driven 0.
- XLEN, 32, data width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- funct3  in  3  instruction funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
- csr_num  in  12  instruction CSR address field
- rs1_field  in  5  rs1 index, or uimm for the immediate forms
- rd_idx  in  5  destination register index
- rs1_data  in  XLEN  rs1 register value
- csr_address  out  ADDR_W  address to the CSR file: {zeros, latched csr_num}
- csr_en_read  out  1  read strobe to the CSR file
- csr_en_write  out  1  write strobe to the CSR file
- csr_wdata  out  XLEN  write data to the CSR file
- csr_rdata  in  XLEN  CSR file data_out; registered, valid the cycle after csr_en_read
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- illegal  out  1  valid with done; instruction trapped
- rd_we  out  1  valid with done; write rd_data to rd_addr
- rd_addr  out  5  latched rd_idx
- rd_data  out  XLEN  old CSR value

Behaviour:
- Reset values: state IDLE; all outputs 0, including csr_address, rd_data and the latches.
- Reset is sampled at the clock edge and overrides everything, including mid-operation. No strobe is asserted in the cycle after the reset edge. A partly completed read-modify-write is abandoned and no done pulse is produced.
- Input capture: on start in IDLE, latch funct3, csr_num, rs1_field, rd_idx and rs1_data. Inputs are ignored while busy. start is ignored in every non-IDLE state.
- Operand: src = funct3[2] ? {27'b0, rs1_field} : rs1_data.
- Decode flags (from latched values):
  - do_read = !(funct3[1:0]==01 && rd_idx==0)
  - do_write = (funct3[1:0]==01) || (rs1_field!=0)
- Illegal conditions, any of:
  - funct3[1:0]==00
  - csr_num not one of 0x301, 0xF11–0xF14, 0x342, 0x300, 0x305, 0x341, 0x344, 0x304, 0xB00, 0xB80, 0xB02, 0xB82, 0x306
  - do_write && csr_num[11:10]==11 (read-only space)
- FSM states and transitions:
  - IDLE: on start go to ERR if illegal, else RD_REQ if do_read, else WR_REQ.
  - RD_REQ: csr_en_read=1 for exactly one cycle; go to RD_WAIT.
  - RD_WAIT: capture csr_rdata into old_q and rd_data at the end of the cycle; go to WR_REQ if do_write, else DONE.
  - WR_REQ: csr_en_write=1 for exactly one cycle.
    - csr_wdata: RW → src; RS → old_q | src; RC → old_q & ~src.
    - For RW with no read, old_q is unused.
    - Go to DONE.
  - DONE: done=1, rd_we = do_read && rd_idx!=0; go to IDLE.
  - ERR: done=1, illegal=1, rd_we=0, no CSR strobes; go to IDLE.
- Outputs are Moore-decoded from registered state and latches. csr_address and csr_wdata hold their value while the corresponding strobe is high.
- Latency from the start cycle to the done cycle:
  - full RMW: 4 cycles
  - read only: 3 cycles
  - write only (RW, rd=x0): 2 cycles
  - illegal: 1 cycle
- A new start is accepted in the cycle after done (IDLE), giving back-to-back throughput of one instruction per latency+1 cycles.
- rd_data and rd_addr hold their value until the next capture. illegal and rd_we are 0 outside the done cycle.

Test Plan:
- Reset, then CSRRW 0x305, rs1_data=0x8000_0100, rd=5 → RD_REQ strobe at cycle 1, write of 0x8000_0100 at cycle 3, done at cycle 4 with rd_we=1, rd_addr=5, rd_data=0.
- With mtvec=0x0000_00F0: CSRRS 0x305 rs1_data=0x0F0F_0000 → csr_wdata=0x0F0F_00F0, rd_data=0xF0. Then CSRRCI 0x305 uimm=0x10 → csr_wdata=0x0F0F_00E0.
- CSRRS 0xF14 with rs1_field=0 → read only, no csr_en_write, done at cycle 3. CSRRW 0xF14 → done at cycle 1 with illegal=1 and no strobes.
- CSRRW 0x341 with rd=0 → no csr_en_read, csr_en_write at cycle 1, done at cycle 2 with rd_we=0. csr_num=0x7C0 → illegal.
- Assert start every cycle during an RMW → only the first request executes; csr_en_read and csr_en_write are never high together in any cycle.
- Assert reset during RD_WAIT → next cycle busy=0, no write strobe, no done pulse. A following start executes normally.

Source files
------------

// File: rtl/csr_access_unit_if.sv
// CSR register file port: address, read/write strobes, write data out, registered read data back.
// master = access unit (initiator), slave = CSR file.
interface csr_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  logic [ADDR_W-1:0] csr_address;
  logic              csr_en_read;
  logic              csr_en_write;
  logic [XLEN-1:0]   csr_wdata;
  logic [XLEN-1:0]   csr_rdata;

  modport master (
    output csr_address,
    output csr_en_read,
    output csr_en_write,
    output csr_wdata,
    input  csr_rdata
  );

  modport slave (
    input  csr_address,
    input  csr_en_read,
    input  csr_en_write,
    input  csr_wdata,
    output csr_rdata
  );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr initiator: read strobe, capture old value, write strobe, return old value for rd.
// Start-to-done latency 4/3/2/1 cycles (RMW/read/write/illegal); start is ignored while busy.
module csr_access_unit #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [11:0]       csr_num,
  input  logic [4:0]        rs1_field,
  input  logic [4:0]        rd_idx,
  input  logic [XLEN-1:0]   rs1_data,
  csr_access_unit_if.master csr,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              rd_we,
  output logic [4:0]        rd_addr,
  output logic [XLEN-1:0]   rd_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q;
  logic [11:0]       csr_num_q;
  logic [4:0]        rs1_field_q;
  logic [4:0]        rd_idx_q;
  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   old_q;
  logic              capture;

  function automatic logic csr_known(input logic [11:0] num);
    case (num)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h306,
      12'h341, 12'h342, 12'h344,
      12'hF11, 12'hF12, 12'hF13, 12'hF14,
      12'hB00, 12'hB02, 12'hB80, 12'hB82: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic dec_read(input logic [2:0] f3, input logic [4:0] rd);
    return !((f3[1:0] == 2'b01) && (rd == 5'd0));
  endfunction

  function automatic logic dec_write(input logic [2:0] f3, input logic [4:0] rs1f);
    return (f3[1:0] == 2'b01) || (rs1f != 5'd0);
  endfunction

  // The IDLE branch decides from the live inputs; later states use the latches.
  logic in_do_read, in_do_write, in_illegal;
  logic lat_do_read, lat_do_write;

  always_comb begin
    in_do_read   = dec_read(funct3, rd_idx);
    in_do_write  = dec_write(funct3, rs1_field);
    in_illegal   = (funct3[1:0] == 2'b00) || !csr_known(csr_num) ||
                   (in_do_write && (csr_num[11:10] == 2'b11));
    lat_do_read  = dec_read(funct3_q, rd_idx_q);
    lat_do_write = dec_write(funct3_q, rs1_field_q);
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (in_illegal)      state_d = S_ERR;
          else if (in_do_read) state_d = S_RD_REQ;
          else                 state_d = S_WR_REQ;
        end
      end
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = lat_do_write ? S_WR_REQ : S_DONE;
      S_WR_REQ:  state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_ERR:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      funct3_q    <= 3'd0;
      csr_num_q   <= 12'd0;
      rs1_field_q <= 5'd0;
      rd_idx_q    <= 5'd0;
      rs1_data_q  <= '0;
      old_q       <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        funct3_q    <= funct3;
        csr_num_q   <= csr_num;
        rs1_field_q <= rs1_field;
        rd_idx_q    <= rd_idx;
        rs1_data_q  <= rs1_data;
      end
      if (state_q == S_RD_WAIT) old_q <= csr.csr_rdata;
    end
  end

  logic [XLEN-1:0] src;
  logic [XLEN-1:0] wdata;

  always_comb begin
    src = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_field_q} : rs1_data_q;
    case (funct3_q[1:0])
      2'b10:   wdata = old_q | src;
      2'b11:   wdata = old_q & ~src;
      default: wdata = src;
    endcase
  end

  // Read and write strobes come from distinct states, so they can never overlap.
  always_comb begin
    csr.csr_address  = {{(ADDR_W-12){1'b0}}, csr_num_q};
    csr.csr_en_read  = (state_q == S_RD_REQ);
    csr.csr_en_write = (state_q == S_WR_REQ);
    csr.csr_wdata    = (state_q == S_WR_REQ) ? wdata : '0;
    busy             = (state_q != S_IDLE);
    done             = (state_q == S_DONE) || (state_q == S_ERR);
    illegal          = (state_q == S_ERR);
    rd_we            = (state_q == S_DONE) && lat_do_read && (rd_idx_q != 5'd0);
    rd_addr          = rd_idx_q;
    rd_data          = old_q;
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: CSR file model on the bus, directed scenarios and random instructions vs a reference.
module tb_csr_access_unit;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [11:0] csr_num;
  logic [4:0]  rs1_field, rd_idx;
  logic [31:0] rs1_data;
  logic        busy, done, illegal, rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        file_init;

  int total = 0;
  int bad   = 0;

  csr_access_unit_if #(.ADDR_W(32), .XLEN(32)) bus ();

  csr_access_unit #(.ADDR_W(32), .XLEN(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .funct3    (funct3),
    .csr_num   (csr_num),
    .rs1_field (rs1_field),
    .rd_idx    (rd_idx),
    .rs1_data  (rs1_data),
    .csr       (bus),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal),
    .rd_we     (rd_we),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #5 clock = ~clock;

  localparam logic [11:0] LEGAL [16] = '{12'h301, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h342,
                                         12'h300, 12'h305, 12'h341, 12'h344, 12'h304, 12'hB00,
                                         12'hB80, 12'hB02, 12'hB82, 12'h306};

  // CSR file: registered read data, write wins over read.
  logic [31:0] file_mem [4096];
  always @(posedge clock) begin
    if (file_init) begin
      for (int i = 0; i < 4096; i++) file_mem[i] <= 32'h0;
      file_mem[12'hF11] <= 32'h0000_0489;
      file_mem[12'hF12] <= 32'h0000_0012;
      file_mem[12'hF13] <= 32'h0000_0034;
      file_mem[12'hF14] <= 32'h0000_0003;
    end else if (bus.csr_en_write) begin
      file_mem[bus.csr_address[11:0]] <= bus.csr_wdata;
    end else if (bus.csr_en_read) begin
      bus.csr_rdata <= file_mem[bus.csr_address[11:0]];
    end
  end

  typedef struct {
    int          rd_cyc, wr_cyc, n_rd, n_wr, done_cyc;
    bit          both, addr_bad, spurious, busy_bad;
    logic [31:0] wdata, rd_data;
    logic        ill, we;
    logic [4:0]  raddr;
  } obs_t;

  typedef struct {
    int          rd_cyc, wr_cyc, n_rd, n_wr, done_cyc;
    logic [31:0] wdata, rd_data;
    logic        ill, we;
    logic [4:0]  raddr;
  } exp_t;

  // Reference: architectural CSR contents and last value returned to rd.
  logic [31:0] ref_mem [4096];
  logic [31:0] last_rd;

  task automatic ref_step(input logic [2:0] f3, input logic [11:0] c, input logic [4:0] r1,
                          input logic [4:0] rd, input logic [31:0] d, output exp_t e);
    bit known, rdd, wr, ill;
    logic [31:0] src, old;
    int t;
    known = 0;
    foreach (LEGAL[i]) if (LEGAL[i] == c) known = 1;
    wr  = (f3[1:0] == 2'b01) || (r1 != 0);
    rdd = !((f3[1:0] == 2'b01) && (rd == 0));
    ill = (f3[1:0] == 2'b00) || !known || (wr && c[11:10] == 2'b11);
    e = '{default: 0};
    e.raddr = rd;
    if (ill) begin
      e.ill = 1; e.done_cyc = 1; e.rd_data = last_rd;
      return;
    end
    old = ref_mem[c];
    src = f3[2] ? {27'b0, r1} : d;
    t = 1;
    if (rdd) begin e.rd_cyc = 1; e.n_rd = 1; t = 3; last_rd = old; end
    if (wr) begin
      e.wr_cyc = t; e.n_wr = 1; t++;
      case (f3[1:0])
        2'b01:   e.wdata = src;
        2'b10:   e.wdata = old | src;
        default: e.wdata = old & ~src;
      endcase
      ref_mem[c] = e.wdata;
    end
    e.done_cyc = t;
    e.we = rdd && (rd != 0);
    e.rd_data = last_rd;
  endtask

  // Issue one instruction (start in cycle 0) and observe the bus until done, bounded to 12 cycles.
  task automatic exec(input logic [2:0] f3, input logic [11:0] c, input logic [4:0] r1,
                      input logic [4:0] rd, input logic [31:0] d, input bit hammer, output obs_t o);
    o = '{default: 0};
    @(negedge clock);
    funct3 = f3; csr_num = c; rs1_field = r1; rd_idx = rd; rs1_data = d; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (bus.csr_en_read === 1'b1) begin o.n_rd++; if (o.rd_cyc == 0) o.rd_cyc = k; end
      if (bus.csr_en_write === 1'b1) begin
        o.n_wr++; if (o.wr_cyc == 0) o.wr_cyc = k; o.wdata = bus.csr_wdata;
      end
      if (bus.csr_en_read === 1'b1 && bus.csr_en_write === 1'b1) o.both = 1;
      if ((bus.csr_en_read === 1'b1 || bus.csr_en_write === 1'b1) && bus.csr_address !== {20'b0, c})
        o.addr_bad = 1;
      if (busy !== 1'b1) o.busy_bad = 1;
      if (done === 1'b1) begin
        o.done_cyc = k; o.ill = illegal; o.we = rd_we; o.raddr = rd_addr; o.rd_data = rd_data;
        start = 1'b0;
        break;
      end
      if (illegal !== 1'b0 || rd_we !== 1'b0) o.spurious = 1;
      start = hammer;
      funct3 = 3'($urandom); csr_num = 12'($urandom); rs1_field = 5'($urandom);
      rd_idx = 5'($urandom); rs1_data = $urandom;
    end
  endtask

  task automatic run(input logic [2:0] f3, input logic [11:0] c, input logic [4:0] r1,
                     input logic [4:0] rd, input logic [31:0] d, input bit hammer,
                     output obs_t o, output exp_t e);
    ref_step(f3, c, r1, rd, d, e);
    exec(f3, c, r1, rd, d, hammer, o);
  endtask

  task automatic test_reset;
    file_init = 1'b1; reset = 1'b1; start = 1'b0;
    funct3 = 0; csr_num = 0; rs1_field = 0; rd_idx = 0; rs1_data = 0;
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
    ref_mem[12'hF11] = 32'h0000_0489; ref_mem[12'hF12] = 32'h0000_0012;
    ref_mem[12'hF13] = 32'h0000_0034; ref_mem[12'hF14] = 32'h0000_0003;
    last_rd = 32'h0;
    repeat (2) @(negedge clock);
    file_init = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0 || rd_we !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: got busy=%b done=%b ill=%b we=%b want 0000", busy, done, illegal, rd_we); end
    total++; if (bus.csr_en_read !== 1'b0 || bus.csr_en_write !== 1'b0) begin
      bad++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", bus.csr_en_read, bus.csr_en_write); end
    total++; if (bus.csr_address !== 32'h0 || bus.csr_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_bus: got addr=%h wdata=%h want 0 0", bus.csr_address, bus.csr_wdata); end
    total++; if (rd_data !== 32'h0 || rd_addr !== 5'h0) begin
      bad++; $display("FAIL reset_rd: got data=%h addr=%h want 0 0", rd_data, rd_addr); end
    reset = 1'b0;
  endtask

  task automatic test_rmw;
    obs_t o; exp_t e;
    run(3'b001, 12'h305, 5'd9, 5'd5, 32'h8000_0100, 1'b0, o, e);
    total++; if (o.rd_cyc !== 1 || o.wr_cyc !== 3 || o.done_cyc !== 4) begin
      bad++; $display("FAIL rmw_timing: got rd=%0d wr=%0d done=%0d want 1 3 4", o.rd_cyc, o.wr_cyc, o.done_cyc); end
    total++; if (o.wdata !== 32'h8000_0100) begin
      bad++; $display("FAIL rmw_wdata: got %h want 80000100", o.wdata); end
    total++; if (o.we !== 1'b1 || o.raddr !== 5'd5 || o.rd_data !== 32'h0 || o.ill !== 1'b0) begin
      bad++; $display("FAIL rmw_result: got we=%b rd=%0d data=%h ill=%b want 1 5 0 0", o.we, o.raddr, o.rd_data, o.ill); end
  endtask

  task automatic test_set_clear;
    obs_t o; exp_t e;
    run(3'b001, 12'h305, 5'd1, 5'd0, 32'h0000_00F0, 1'b0, o, e);
    run(3'b010, 12'h305, 5'd7, 5'd3, 32'h0F0F_0000, 1'b0, o, e);
    total++; if (o.wdata !== 32'h0F0F_00F0 || o.rd_data !== 32'h0000_00F0) begin
      bad++; $display("FAIL csrrs: got wdata=%h rd=%h want 0f0f00f0 000000f0", o.wdata, o.rd_data); end
    run(3'b111, 12'h305, 5'h10, 5'd4, 32'hFFFF_FFFF, 1'b0, o, e);
    total++; if (o.wdata !== 32'h0F0F_00E0 || o.rd_data !== 32'h0F0F_00F0) begin
      bad++; $display("FAIL csrrci: got wdata=%h rd=%h want 0f0f00e0 0f0f00f0", o.wdata, o.rd_data); end
  endtask

  task automatic test_read_only;
    obs_t o; exp_t e;
    run(3'b010, 12'hF14, 5'd0, 5'd6, 32'hDEAD_BEEF, 1'b0, o, e);
    total++; if (o.n_wr !== 0 || o.rd_cyc !== 1 || o.done_cyc !== 3) begin
      bad++; $display("FAIL ro_read: got nwr=%0d rd=%0d done=%0d want 0 1 3", o.n_wr, o.rd_cyc, o.done_cyc); end
    total++; if (o.rd_data !== 32'h3 || o.we !== 1'b1) begin
      bad++; $display("FAIL ro_data: got %h we=%b want 3 1", o.rd_data, o.we); end
    run(3'b001, 12'hF14, 5'd2, 5'd6, 32'h1, 1'b0, o, e);
    total++; if (o.done_cyc !== 1 || o.ill !== 1'b1 || o.n_rd !== 0 || o.n_wr !== 0 || o.we !== 1'b0) begin
      bad++; $display("FAIL ro_write: got done=%0d ill=%b nrd=%0d nwr=%0d we=%b want 1 1 0 0 0",
                      o.done_cyc, o.ill, o.n_rd, o.n_wr, o.we); end
  endtask

  task automatic test_write_only;
    obs_t o; exp_t e;
    run(3'b001, 12'h341, 5'd3, 5'd0, 32'h0000_1234, 1'b0, o, e);
    total++; if (o.n_rd !== 0 || o.wr_cyc !== 1 || o.done_cyc !== 2 || o.we !== 1'b0) begin
      bad++; $display("FAIL wo: got nrd=%0d wr=%0d done=%0d we=%b want 0 1 2 0", o.n_rd, o.wr_cyc, o.done_cyc, o.we); end
    run(3'b010, 12'h7C0, 5'd0, 5'd2, 32'h0, 1'b0, o, e);
    total++; if (o.ill !== 1'b1 || o.done_cyc !== 1 || o.n_rd !== 0) begin
      bad++; $display("FAIL bad_csr: got ill=%b done=%0d nrd=%0d want 1 1 0", o.ill, o.done_cyc, o.n_rd); end
    run(3'b100, 12'h300, 5'd1, 5'd2, 32'h5, 1'b0, o, e);
    total++; if (o.ill !== 1'b1 || o.n_wr !== 0) begin
      bad++; $display("FAIL bad_f3: got ill=%b nwr=%0d want 1 0", o.ill, o.n_wr); end
  endtask

  task automatic test_back_to_back;
    obs_t o; exp_t e;
    run(3'b011, 12'h300, 5'd5, 5'd8, 32'h0000_0088, 1'b1, o, e);
    total++; if (o.n_rd !== 1 || o.n_wr !== 1 || o.both !== 1'b0 || o.done_cyc !== 4) begin
      bad++; $display("FAIL hammer: got nrd=%0d nwr=%0d both=%b done=%0d want 1 1 0 4", o.n_rd, o.n_wr, o.both, o.done_cyc); end
    run(3'b001, 12'h300, 5'd1, 5'd9, 32'hCAFE_0001, 1'b0, o, e);
    total++; if (o.done_cyc !== 4 || o.rd_data !== 32'h0 || o.wdata !== 32'hCAFE_0001) begin
      bad++; $display("FAIL b2b: got done=%0d rd=%h wdata=%h want 4 0 cafe0001", o.done_cyc, o.rd_data, o.wdata); end
    @(negedge clock);
    total++; if (busy !== 1'b0 || file_mem[12'h300] !== 32'hCAFE_0001) begin
      bad++; $display("FAIL b2b_idle: got busy=%b mstatus=%h want 0 cafe0001", busy, file_mem[12'h300]); end
  endtask

  task automatic test_reset_mid;
    obs_t o; exp_t e;
    int strobes, dones;
    @(negedge clock);
    funct3 = 3'b010; csr_num = 12'h305; rs1_field = 5'd4; rd_idx = 5'd7; rs1_data = 32'hFFFF_0000; start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    total++; if (busy !== 1'b0 || bus.csr_en_write !== 1'b0 || done !== 1'b0 || rd_data !== 32'h0) begin
      bad++; $display("FAIL reset_mid: got busy=%b wr=%b done=%b rd=%h want 0 0 0 0", busy, bus.csr_en_write, done, rd_data); end
    last_rd = 32'h0;
    strobes = 0; dones = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (bus.csr_en_read === 1'b1 || bus.csr_en_write === 1'b1) strobes++;
      if (done === 1'b1) dones++;
    end
    total++; if (strobes != 0 || dones != 0) begin
      bad++; $display("FAIL reset_quiet: got strobes=%0d dones=%0d want 0 0", strobes, dones); end
    run(3'b010, 12'h305, 5'd0, 5'd1, 32'h0, 1'b0, o, e);
    total++; if (o.done_cyc !== 3 || o.rd_data !== 32'h0F0F_00E0 || o.we !== 1'b1) begin
      bad++; $display("FAIL after_reset: got done=%0d rd=%h we=%b want 3 0f0f00e0 1", o.done_cyc, o.rd_data, o.we); end
  endtask

  task automatic test_random;
    obs_t o; exp_t e;
    logic [2:0] f3; logic [11:0] c; logic [4:0] r1, rd;
    for (int n = 0; n < 80; n++) begin
      f3 = 3'($urandom);
      c  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : LEGAL[$urandom_range(0, 15)];
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run(f3, c, r1, rd, $urandom, n[0], o, e);
      total++; if (o.done_cyc !== e.done_cyc || o.ill !== e.ill) begin
        bad++; $display("FAIL rnd%0d_done: got cyc=%0d ill=%b want %0d %b", n, o.done_cyc, o.ill, e.done_cyc, e.ill); end
      total++; if (o.n_rd !== e.n_rd || o.rd_cyc !== e.rd_cyc || o.n_wr !== e.n_wr || o.wr_cyc !== e.wr_cyc) begin
        bad++; $display("FAIL rnd%0d_strobes: got rd=%0d@%0d wr=%0d@%0d want %0d@%0d %0d@%0d", n,
                        o.n_rd, o.rd_cyc, o.n_wr, o.wr_cyc, e.n_rd, e.rd_cyc, e.n_wr, e.wr_cyc); end
      if (e.n_wr != 0) begin
        total++; if (o.wdata !== e.wdata) begin
          bad++; $display("FAIL rnd%0d_wdata: got %h want %h", n, o.wdata, e.wdata); end
      end
      total++; if (o.we !== e.we || o.raddr !== e.raddr || o.rd_data !== e.rd_data) begin
        bad++; $display("FAIL rnd%0d_rd: got we=%b a=%0d d=%h want %b %0d %h", n, o.we, o.raddr, o.rd_data, e.we, e.raddr, e.rd_data); end
      total++; if (o.both || o.addr_bad || o.spurious || o.busy_bad) begin
        bad++; $display("FAIL rnd%0d_proto: got both=%b addr=%b spur=%b busy=%b want 0000", n, o.both, o.addr_bad, o.spurious, o.busy_bad); end
    end
    foreach (LEGAL[i]) begin
      total++; if (file_mem[LEGAL[i]] !== ref_mem[LEGAL[i]]) begin
        bad++; $display("FAIL csr_%h: got %h want %h", LEGAL[i], file_mem[LEGAL[i]], ref_mem[LEGAL[i]]); end
    end
  endtask

  initial begin
    test_reset();
    test_rmw();
    test_set_clear();
    test_read_only();
    test_write_only();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
